// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: two-slave address decoder with in-order read tracking; MEM_BUS_DECODER_ERR_EN enables the sticky bus error
module mem_bus_decoder #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        s0_ready,
    output logic [31:0] s0_addr,
    output logic [31:0] s0_write_data,
    output logic [3:0]  s0_byte_enable,
    output logic        s0_write_req,
    output logic        s0_read_req,
    input  logic [31:0] s0_read_data,
    input  logic        s0_read_data_valid,
    input  logic        s1_ready,
    output logic [31:0] s1_addr,
    output logic [31:0] s1_write_data,
    output logic [3:0]  s1_byte_enable,
    output logic        s1_write_req,
    output logic        s1_read_req,
    input  logic [31:0] s1_read_data,
    input  logic        s1_read_data_valid,
    output logic        bus_error,
    output logic [31:0] bus_error_addr
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] count;
    logic [1:0]    tag;
    logic [1:0]    target;
    logic          unmapped_pending;
    logic          gate;
    logic          rd_acc;
    logic          accept;

    always_comb begin
        target = addr[31:28] == 4'h1 ? 2'd0 : addr[31:28] == 4'h2 ? 2'd1 : 2'd2;
        read_data_valid = count != '0 && (tag == 2'd0 ? s0_read_data_valid :
                                          tag == 2'd1 ? s1_read_data_valid : unmapped_pending);
        read_data = !read_data_valid ? 32'h0 : tag == 2'd0 ? s0_read_data :
                    tag == 2'd1 ? s1_read_data : 32'h0;
        // a full counter still admits a same-target read when a response frees a slot this cycle
        gate = count == '0 || (tag == target && (count < CW'(MAX_OUTSTANDING) || read_data_valid));
        ready = reset ? 1'b0 :
                target == 2'd0 ? s0_ready && (write_req || gate) :
                target == 2'd1 ? s1_ready && (write_req || gate) :
                write_req ? 1'b1 : gate;
        rd_acc = ready && read_req;
        accept = ready && (read_req || write_req);
        s0_read_req = read_req && target == 2'd0 && gate && !reset;
        s1_read_req = read_req && target == 2'd1 && gate && !reset;
        s0_write_req = write_req && target == 2'd0 && !reset;
        s1_write_req = write_req && target == 2'd1 && !reset;
        s0_addr = addr;
        s1_addr = addr;
        s0_write_data = write_data;
        s1_write_data = write_data;
        s0_byte_enable = byte_enable;
        s1_byte_enable = byte_enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tag <= 2'd0;
            unmapped_pending <= 1'b0;
        end else begin
            count <= count + CW'(rd_acc) - CW'(read_data_valid);
            tag <= rd_acc ? target : tag;
            unmapped_pending <= rd_acc && target == 2'd2;
        end
    end

`ifdef MEM_BUS_DECODER_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_error <= 1'b0;
            bus_error_addr <= 32'h0;
        end else if (accept && target == 2'd2 && !bus_error) begin
            bus_error <= 1'b1;
            bus_error_addr <= addr;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign bus_error = 1'b0;
    assign bus_error_addr = 32'h0;
`endif
endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: table-driven directed check of decode, gating, ordering, reset and bus error
module tb_mem_bus_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        s0_ready;
    logic [31:0] s0_addr;
    logic [31:0] s0_write_data;
    logic [3:0]  s0_byte_enable;
    logic        s0_write_req;
    logic        s0_read_req;
    logic [31:0] s0_read_data;
    logic        s0_read_data_valid;
    logic        s1_ready;
    logic [31:0] s1_addr;
    logic [31:0] s1_write_data;
    logic [3:0]  s1_byte_enable;
    logic        s1_write_req;
    logic        s1_read_req;
    logic [31:0] s1_read_data;
    logic        s1_read_data_valid;
    logic        bus_error;
    logic [31:0] bus_error_addr;

    int checks = 0;
    int fails = 0;

    mem_bus_decoder #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .reset(reset), .ready(ready), .addr(addr), .write_data(write_data),
        .byte_enable(byte_enable), .write_req(write_req), .read_req(read_req),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_write_data(s0_write_data),
        .s0_byte_enable(s0_byte_enable), .s0_write_req(s0_write_req), .s0_read_req(s0_read_req),
        .s0_read_data(s0_read_data), .s0_read_data_valid(s0_read_data_valid),
        .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_write_data(s1_write_data),
        .s1_byte_enable(s1_byte_enable), .s1_write_req(s1_write_req), .s1_read_req(s1_read_req),
        .s1_read_data(s1_read_data), .s1_read_data_valid(s1_read_data_valid),
        .bus_error(bus_error), .bus_error_addr(bus_error_addr)
    );

    always #5 clk = ~clk;

    // flags = {ready, s0_read_req, s1_read_req, s0_write_req, s1_write_req, read_data_valid, bus_error}
    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] a;
        logic        s0r, s1r, s0v, s1v;
        logic [31:0] s0d, s1d;
        logic [6:0]  flags;
        logic [31:0] rdata;
    } vec_t;

    vec_t v[31];

    function automatic vec_t mk(logic rst, logic rd, logic wr, logic [31:0] a, logic s0r, logic s1r,
                                logic s0v, logic s1v, logic [31:0] s0d, logic [31:0] s1d,
                                logic [6:0] flags, logic [31:0] rdata);
        vec_t r;
        r.rst = rst; r.rd = rd; r.wr = wr; r.a = a; r.s0r = s0r; r.s1r = s1r;
        r.s0v = s0v; r.s1v = s1v; r.s0d = s0d; r.s1d = s1d; r.flags = flags; r.rdata = rdata;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [6:0]  gf;
        logic [6:0]  ef;
        logic [31:0] ea;
        v[0]  = mk(1, 1, 0, 32'h1000_0000, 1, 0, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000000, 32'h0);
        v[1]  = mk(0, 1, 0, 32'h1000_0000, 1, 0, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1100000, 32'h0);
        v[2]  = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000000, 32'h0);
        v[3]  = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000000, 32'h0);
        v[4]  = mk(0, 0, 0, 32'h0,         1, 1, 1, 0, 32'hCAFEBABE, 32'hBBBB0000, 7'b0000010, 32'hCAFEBABE);
        v[5]  = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000000, 32'h0);
        v[6]  = mk(0, 1, 0, 32'h1000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1100000, 32'h0);
        v[7]  = mk(0, 1, 0, 32'h2000_0004, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000000, 32'h0);
        v[8]  = mk(0, 1, 0, 32'h2000_0004, 1, 1, 1, 0, 32'h11111111, 32'hBBBB0000, 7'b0000010, 32'h11111111);
        v[9]  = mk(0, 1, 0, 32'h2000_0004, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1010000, 32'h0);
        v[10] = mk(0, 0, 0, 32'h0,         1, 1, 1, 1, 32'hDEADBEEF, 32'h22222222, 7'b0000010, 32'h22222222);
        v[11] = mk(0, 0, 0, 32'h0,         1, 1, 1, 0, 32'hDEADBEEF, 32'hBBBB0000, 7'b1000000, 32'h0);
        v[12] = mk(0, 0, 1, 32'h2000_0008, 1, 0, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000100, 32'h0);
        v[13] = mk(0, 0, 1, 32'h2000_0008, 1, 0, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000100, 32'h0);
        v[14] = mk(0, 0, 1, 32'h2000_0008, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000100, 32'h0);
        v[15] = mk(0, 1, 0, 32'h3000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000000, 32'h0);
        v[16] = mk(0, 0, 0, 32'h0,         1, 1, 1, 0, 32'hDEADBEEF, 32'hBBBB0000, 7'b1000011, 32'h0);
        v[17] = mk(0, 0, 1, 32'h4000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000001, 32'h0);
        v[18] = mk(0, 1, 0, 32'h5000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000001, 32'h0);
        v[19] = mk(0, 1, 0, 32'h5000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000011, 32'h0);
        v[20] = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000011, 32'h0);
        v[21] = mk(0, 0, 0, 32'h0,         1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1000001, 32'h0);
        for (int i = 22; i < 26; i++)
            v[i] = mk(0, 1, 0, 32'h1000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b1100001, 32'h0);
        v[26] = mk(0, 1, 0, 32'h1000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000001, 32'h0);
        v[27] = mk(0, 1, 0, 32'h1000_0000, 1, 1, 1, 0, 32'h33333333, 32'hBBBB0000, 7'b1100011, 32'h33333333);
        v[28] = mk(0, 1, 0, 32'h1000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000001, 32'h0);
        v[29] = mk(1, 0, 0, 32'h1000_0000, 1, 1, 0, 0, 32'hAAAA0000, 32'hBBBB0000, 7'b0000001, 32'h0);
        v[30] = mk(0, 0, 0, 32'h1000_0000, 1, 1, 1, 0, 32'h44444444, 32'hBBBB0000, 7'b1000000, 32'h0);

        reset = 1'b1; addr = 32'h0; write_data = 32'h12345678; byte_enable = 4'b0011;
        write_req = 1'b0; read_req = 1'b0; s0_ready = 1'b0; s1_ready = 1'b0;
        s0_read_data = 32'h0; s1_read_data = 32'h0; s0_read_data_valid = 1'b0; s1_read_data_valid = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            reset = v[i].rst; read_req = v[i].rd; write_req = v[i].wr; addr = v[i].a;
            s0_ready = v[i].s0r; s1_ready = v[i].s1r;
            s0_read_data_valid = v[i].s0v; s1_read_data_valid = v[i].s1v;
            s0_read_data = v[i].s0d; s1_read_data = v[i].s1d;
            #1;
            gf = {ready, s0_read_req, s1_read_req, s0_write_req, s1_write_req, read_data_valid, bus_error};
`ifdef MEM_BUS_DECODER_ERR_EN
            ef = v[i].flags;
            ea = v[i].flags[0] ? 32'h3000_0000 : 32'h0;
`else
            ef = {v[i].flags[6:1], 1'b0};
            ea = 32'h0;
`endif
            check($sformatf("flags[%0d]", i), {25'h0, gf}, {25'h0, ef});
            check($sformatf("read_data[%0d]", i), read_data, v[i].rdata);
            check($sformatf("bus_error_addr[%0d]", i), bus_error_addr, ea);
        end

        @(negedge clk);
        addr = 32'h2000_00C0; write_data = 32'h9ABCDEF0; byte_enable = 4'b1010;
        read_req = 1'b0; write_req = 1'b0; s0_read_data_valid = 1'b0;
        #1;
        check("s0_addr", s0_addr, 32'h2000_00C0);
        check("s1_addr", s1_addr, 32'h2000_00C0);
        check("s0_write_data", s0_write_data, 32'h9ABCDEF0);
        check("s1_write_data", s1_write_data, 32'h9ABCDEF0);
        check("s0_byte_enable", {28'h0, s0_byte_enable}, 32'hA);
        check("s1_byte_enable", {28'h0, s1_byte_enable}, 32'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
